cdc_tx_handshake_ctrl: RTL and testbench

Source-domain controller for a 4-phase req/ack multi-bit clock-domain crossing. It accepts one word from a local producer, holds it stable on XFER_DATA, and drives REQ. It waits for the remote ACK through an internal NUM_STAGES-deep synchronizer, then completes the return-to-zero phase. It sits beside the system's bit synchronizers as the sequencing logic for any bus wider than one bit that crosses out of the CLK domain, and it bounds every wait with a timeout.

---
 rtl/cdc_tx_handshake_ctrl_pkg.sv | 19 +
 rtl/cdc_tx_handshake_ctrl_sync.sv | 21 ++
 rtl/cdc_tx_handshake_ctrl.sv | 107 ++++++++++
 tb/tb_cdc_tx_handshake_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_tx_handshake_ctrl_pkg.sv
// Shared definitions for the source-side CDC handshake controller:
// FSM state encoding and timeout counter sizing.
package cdc_tx_handshake_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'b00,
      WAIT_ACK_HI = 2'b01,
      WAIT_ACK_LO = 2'b10
   } state_t;

   // ceil(log2(cycles+1)), never below one bit so a disabled timeout still elaborates
   function automatic int cnt_width(input int cycles);
      int w;
      w = 1;
      while ((1 << w) < (cycles + 1)) w++;
      return w;
   endfunction

endpackage

// File: rtl/cdc_tx_handshake_ctrl_sync.sv
// Multi-flop synchronizer chain; only the last stage is meant to be consumed.
module ack_sync_chain #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [DEPTH-1:0][WIDTH-1:0] sync_q;

   always_ff @(posedge CLK) begin
      if (RST) sync_q <= '0;
      else     sync_q <= {sync_q[DEPTH-2:0], d};
   end

   assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/cdc_tx_handshake_ctrl.sv
// Source-domain 4-phase req/ack sequencer: captures one word, raises REQ,
// waits for the synchronized ACK to rise and fall, with a bounded wait in each phase.
module cdc_tx_handshake_ctrl
   import cdc_tx_handshake_ctrl_pkg::*;
#(
   parameter int BUS_WIDTH      = 8,
   parameter int NUM_STAGES     = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] TX_DATA,
   input  logic                 TX_VALID,
   output logic                 TX_READY,
   output logic [BUS_WIDTH-1:0] XFER_DATA,
   output logic                 REQ,
   input  logic                 ACK_ASYNC,
   output logic                 DONE,
   output logic                 TIMEOUT_ERR,
   input  logic                 CLR_ERR
);

   localparam int             CW      = cnt_width(TIMEOUT_CYCLES);
   localparam bit             TO_EN   = (TIMEOUT_CYCLES > 0);
   localparam logic [CW-1:0]  TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          ack_s;
   logic          to_hit;
   logic          aborted;

   ack_sync_chain #(
      .WIDTH (1),
      .DEPTH (NUM_STAGES)
   ) u_ack_sync (
      .CLK (CLK),
      .RST (RST),
      .d   (ACK_ASYNC),
      .q   (ack_s)
   );

   assign to_hit   = TO_EN && (cnt == TO_LAST);
   assign TX_READY = (state == IDLE);

   // Expected ack_s value is tested before to_hit so a coincident timeout loses.
   // 'aborted' suppresses DONE for the return-to-zero that follows a high-phase timeout.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         cnt         <= '0;
         REQ         <= 1'b0;
         XFER_DATA   <= '0;
         DONE        <= 1'b0;
         TIMEOUT_ERR <= 1'b0;
         aborted     <= 1'b0;
      end else begin
         DONE <= 1'b0;
         if (CLR_ERR) TIMEOUT_ERR <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (TX_VALID) begin
                  XFER_DATA <= TX_DATA;
                  REQ       <= 1'b1;
                  aborted   <= 1'b0;
                  state     <= WAIT_ACK_HI;
               end
            end
            WAIT_ACK_HI: begin
               if (ack_s) begin
                  REQ   <= 1'b0;
                  cnt   <= '0;
                  state <= WAIT_ACK_LO;
               end else if (to_hit) begin
                  REQ         <= 1'b0;
                  cnt         <= '0;
                  TIMEOUT_ERR <= 1'b1;
                  aborted     <= 1'b1;
                  state       <= WAIT_ACK_LO;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WAIT_ACK_LO: begin
               if (!ack_s) begin
                  DONE  <= !aborted;
                  cnt   <= '0;
                  state <= IDLE;
               end else if (to_hit) begin
                  TIMEOUT_ERR <= 1'b1;
                  cnt         <= '0;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               REQ   <= 1'b0;
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cdc_tx_handshake_ctrl.sv
// Directed + randomized bench; expected timing comes from the handshake latency rules.
module tb_cdc_tx_handshake_ctrl;

   localparam int BW = 8;
   localparam int NS = 2;
   localparam int TO = 16;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [BW-1:0] TX_DATA = '0;
   logic          TX_VALID = 1'b0;
   logic          TX_READY;
   logic [BW-1:0] XFER_DATA;
   logic          REQ;
   logic          ACK_ASYNC = 1'b0;
   logic          DONE;
   logic          TIMEOUT_ERR;
   logic          CLR_ERR = 1'b0;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int done_cnt = 0;
   int stab_err = 0;
   logic          prev_req = 1'b0;
   logic [BW-1:0] prev_x = '0;

   cdc_tx_handshake_ctrl #(
      .BUS_WIDTH      (BW),
      .NUM_STAGES     (NS),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .TX_DATA     (TX_DATA),
      .TX_VALID    (TX_VALID),
      .TX_READY    (TX_READY),
      .XFER_DATA   (XFER_DATA),
      .REQ         (REQ),
      .ACK_ASYNC   (ACK_ASYNC),
      .DONE        (DONE),
      .TIMEOUT_ERR (TIMEOUT_ERR),
      .CLR_ERR     (CLR_ERR)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   // DONE pulse counting and XFER_DATA stability while REQ is held
   always @(negedge CLK) begin
      if (DONE === 1'b1) done_cnt++;
      if (REQ === 1'b1 && prev_req === 1'b1 && XFER_DATA !== prev_x) stab_err++;
      prev_req = REQ;
      prev_x   = XFER_DATA;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (TX_READY !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      chk("wait_ready", 32'(TX_READY), 32'd1);
   endtask

   task automatic wait_req_low();
      int n;
      n = 0;
      while (REQ !== 1'b0 && n < 64) begin
         tick();
         n++;
      end
      chk("wait_req_low", 32'(REQ), 32'd0);
   endtask

   task automatic send(input logic [BW-1:0] w, output int n_acc);
      TX_DATA  = w;
      TX_VALID = 1'b1;
      wait_ready();
      tick();
      TX_VALID = 1'b0;
      TX_DATA  = ~w;
      n_acc    = cyc;
      chk("acc_req",  32'(REQ), 32'd1);
      chk("acc_data", 32'(XFER_DATA), 32'(w));
      chk("acc_rdy",  32'(TX_READY), 32'd0);
   endtask

   // Full clean transfer; the remote side waits d_hi/d_lo cycles before each ACK edge.
   task automatic xfer(input logic [BW-1:0] w, input int d_hi, input int d_lo);
      int n_acc, m, f, d0;
      send(w, n_acc);
      repeat (d_hi) tick();
      ACK_ASYNC = 1'b1;
      m = cyc + 1;
      wait_req_low();
      chk("req_fall_time", 32'(cyc), 32'(m + NS));
      chk("hold_data", 32'(XFER_DATA), 32'(w));
      repeat (d_lo) tick();
      ACK_ASYNC = 1'b0;
      f  = cyc + 1;
      d0 = done_cnt;
      wait_ready();
      chk("idle_time", 32'(cyc), 32'(f + NS));
      chk("done_hi", 32'(DONE), 32'd1);
      tick();
      chk("done_lo", 32'(DONE), 32'd0);
      chk("done_once", 32'(done_cnt), 32'(d0 + 1));
      chk("err_clean", 32'(TIMEOUT_ERR), 32'd0);
   endtask

   initial begin
      int n, l, d0;
      int acc[3];
      logic [BW-1:0] bw[3];

      // reset state
      tick();
      tick();
      chk("rst_req",   32'(REQ), 32'd0);
      chk("rst_data",  32'(XFER_DATA), 32'd0);
      chk("rst_done",  32'(DONE), 32'd0);
      chk("rst_err",   32'(TIMEOUT_ERR), 32'd0);
      chk("rst_ready", 32'(TX_READY), 32'd1);
      RST = 1'b0;
      tick();

      // basic transfer, ACK three cycles after REQ
      xfer(8'hA5, 3, 3);

      // back-to-back with immediate remote acknowledge
      bw[0] = 8'h01; bw[1] = 8'h02; bw[2] = 8'h03;
      d0 = done_cnt;
      TX_DATA  = bw[0];
      TX_VALID = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_ready();
         tick();
         acc[k] = cyc;
         chk("b2b_data", 32'(XFER_DATA), 32'(bw[k]));
         if (k < 2) TX_DATA = bw[k+1];
         else begin
            TX_VALID = 1'b0;
            TX_DATA  = 8'hFF;
         end
         ACK_ASYNC = 1'b1;
         wait_req_low();
         chk("b2b_hold", 32'(XFER_DATA), 32'(bw[k]));
         ACK_ASYNC = 1'b0;
      end
      wait_ready();
      tick();
      chk("b2b_space01", 32'(acc[1] - acc[0]), 32'(2 * NS + 3));
      chk("b2b_space12", 32'(acc[2] - acc[1]), 32'(2 * NS + 3));
      chk("b2b_done",    32'(done_cnt - d0), 32'd3);

      // high-phase timeout: ACK never rises
      send(8'h5A, n);
      wait_req_low();
      chk("to_hi_time", 32'(cyc), 32'(n + TO));
      chk("to_hi_err",  32'(TIMEOUT_ERR), 32'd1);
      d0 = done_cnt;
      wait_ready();
      chk("to_hi_idle", 32'(cyc), 32'(n + TO + 1));
      tick();
      chk("to_hi_nodone", 32'(done_cnt), 32'(d0));
      chk("to_hi_data",   32'(XFER_DATA), 32'h5A);
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      chk("clr_err", 32'(TIMEOUT_ERR), 32'd0);

      // stuck-high ACK: low-phase timeout
      send(8'hC3, n);
      ACK_ASYNC = 1'b1;
      wait_req_low();
      chk("stuck_req_fall", 32'(cyc), 32'(n + 1 + NS));
      l  = cyc;
      d0 = done_cnt;
      wait_ready();
      chk("to_lo_time", 32'(cyc), 32'(l + TO));
      chk("to_lo_err",  32'(TIMEOUT_ERR), 32'd1);
      chk("to_lo_req",  32'(REQ), 32'd0);
      tick();
      chk("to_lo_nodone", 32'(done_cnt), 32'(d0));
      ACK_ASYNC = 1'b0;
      repeat (NS + 1) tick();
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      xfer(8'h96, 1, 1);

      // reset mid-transfer
      send(8'h3C, n);
      tick();
      tick();
      chk("mid_req",  32'(REQ), 32'd1);
      chk("mid_data", 32'(XFER_DATA), 32'h3C);
      d0 = done_cnt;
      RST = 1'b1;
      tick();
      chk("mid_rst_req",   32'(REQ), 32'd0);
      chk("mid_rst_data",  32'(XFER_DATA), 32'd0);
      chk("mid_rst_ready", 32'(TX_READY), 32'd1);
      chk("mid_rst_done",  32'(DONE), 32'd0);
      RST = 1'b0;
      repeat (4) tick();
      chk("mid_nodone", 32'(done_cnt), 32'(d0));

      // spurious ACK while idle
      ACK_ASYNC = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("spur_ready", 32'(TX_READY), 32'd1);
         chk("spur_req",   32'(REQ), 32'd0);
      end
      ACK_ASYNC = 1'b0;
      repeat (NS + 1) tick();

      // CLR_ERR held across the timeout edge: set wins
      send(8'h77, n);
      CLR_ERR = 1'b1;
      while (cyc < n + TO) tick();
      chk("coll_req", 32'(REQ), 32'd0);
      chk("coll_err", 32'(TIMEOUT_ERR), 32'd1);
      CLR_ERR = 1'b0;
      tick();
      chk("coll_err_hold", 32'(TIMEOUT_ERR), 32'd1);
      chk("coll_idle",     32'(TX_READY), 32'd1);
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      chk("coll_clr", 32'(TIMEOUT_ERR), 32'd0);

      // randomized words and remote response delays
      for (int i = 0; i < 8; i++)
         xfer(8'($urandom_range(0, 255)), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));

      chk("xfer_stable", 32'(stab_err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
